// File: rtl/key_event_decoder_pkg.sv
// Shared types and defaults for the key gesture decoder.
package key_event_decoder_pkg;

  // Gesture states, 3-bit encoding
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PRESSED  = 3'd1,
    ST_HELD     = 3'd2,
    ST_WAIT_DBL = 3'd3,
    ST_SECOND   = 3'd4,
    ST_WAIT_REL = 3'd5
  } key_state_t;

  // Defaults for a 50 MHz clock
  localparam int LONG_CNT_DEF = 50_000_000;  // 1 s hold
  localparam int DBL_CNT_DEF  = 15_000_000;  // 300 ms double-click gap
  localparam int RPT_CNT_DEF  = 10_000_000;  // 200 ms auto-repeat period
  localparam int CNT_W_DEF    = 26;

  // The key is physically down in these states
  function automatic logic is_held_state(key_state_t s);
    return (s == ST_PRESSED) || (s == ST_HELD) ||
           (s == ST_SECOND)  || (s == ST_WAIT_REL);
  endfunction

endpackage

// File: rtl/key_event_decoder_timer.sv
// Up-counter with synchronous clear and a terminal-count compare against a
// per-state limit. Tc fires when the count reaches Limit-1.
module key_event_timer #(
  parameter int CNT_W = 26
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Clear,
  input  logic [CNT_W-1:0] Limit,
  output logic             Tc
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt;

  // Count up each cycle unless cleared by the FSM or reset
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      cnt <= '0;
    end else if (Clear) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + ONE;
    end
  end

  assign Tc = (cnt == (Limit - ONE));

endmodule

// File: rtl/key_event_decoder.sv
// Key gesture classifier: short click, double click, long press, auto-repeat.
//
//  state    | meaning
//  ---------+--------------------------------------------------------------
//  IDLE     | key up, nothing pending
//  PRESSED  | first press, timing toward long press
//  HELD     | long press reached, emitting repeats until release
//  WAIT_DBL | released after short press, waiting for a second press
//  SECOND   | second press down; release or long timeout confirms double
//  WAIT_REL | double already reported, waiting for the key to come up
module key_event_decoder
  import key_event_decoder_pkg::*;
#(
  parameter int LONG_CNT = LONG_CNT_DEF,
  parameter int DBL_CNT  = DBL_CNT_DEF,
  parameter int RPT_CNT  = RPT_CNT_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic Key_P_flag,
  input  logic Key_R_flag,
  output logic Short_flag,
  output logic Double_flag,
  output logic Long_flag,
  output logic Repeat_flag,
  output logic Key_held
);

  localparam logic [CNT_W-1:0] LONG_LIM = CNT_W'(LONG_CNT);
  localparam logic [CNT_W-1:0] DBL_LIM  = CNT_W'(DBL_CNT);
  localparam logic [CNT_W-1:0] RPT_LIM  = CNT_W'(RPT_CNT);

  key_state_t       state, next_state;
  logic [CNT_W-1:0] limit;
  logic             counting;
  logic             restart;
  logic             tc;
  logic             timer_clear;
  logic             short_nxt, double_nxt, long_nxt, repeat_nxt;

  // Counter is held at zero outside the timed states so it can never wrap
  assign timer_clear = !counting || restart || (next_state != state);

  key_event_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .Clear   (timer_clear),
    .Limit   (limit),
    .Tc      (tc)
  );

  // State register and registered event outputs
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state       <= ST_IDLE;
      Short_flag  <= 1'b0;
      Double_flag <= 1'b0;
      Long_flag   <= 1'b0;
      Repeat_flag <= 1'b0;
      Key_held    <= 1'b0;
    end else begin
      state       <= next_state;
      Short_flag  <= short_nxt;
      Double_flag <= double_nxt;
      Long_flag   <= long_nxt;
      Repeat_flag <= repeat_nxt;
      Key_held    <= is_held_state(next_state);
    end
  end

  // Next-state and event decode; an expected flag always beats a timeout
  always_comb begin
    next_state = state;
    limit      = '0;
    counting   = 1'b0;
    restart    = 1'b0;
    short_nxt  = 1'b0;
    double_nxt = 1'b0;
    long_nxt   = 1'b0;
    repeat_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (Key_P_flag) next_state = ST_PRESSED;
      end
      ST_PRESSED: begin
        limit    = LONG_LIM;
        counting = 1'b1;
        if (Key_R_flag) begin
          next_state = ST_WAIT_DBL;
        end else if (tc) begin
          next_state = ST_HELD;
          long_nxt   = 1'b1;
        end
      end
      ST_HELD: begin
        limit    = RPT_LIM;
        counting = 1'b1;
        if (Key_R_flag) begin
          next_state = ST_IDLE;
        end else if (tc) begin
          repeat_nxt = 1'b1;
          restart    = 1'b1;
        end
      end
      ST_WAIT_DBL: begin
        limit    = DBL_LIM;
        counting = 1'b1;
        if (Key_P_flag) begin
          next_state = ST_SECOND;
        end else if (tc) begin
          next_state = ST_IDLE;
          short_nxt  = 1'b1;
        end
      end
      ST_SECOND: begin
        limit    = LONG_LIM;
        counting = 1'b1;
        if (Key_R_flag) begin
          next_state = ST_IDLE;
          double_nxt = 1'b1;
        end else if (tc) begin
          next_state = ST_WAIT_REL;
          double_nxt = 1'b1;
        end
      end
      ST_WAIT_REL: begin
        if (Key_R_flag) next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed bench for key_event_decoder with short sim timing
// (LONG=20, DBL=8, RPT=5). Step i drives inputs sampled at edge i;
// outputs are read 1 time unit after that edge.
module tb_key_event_decoder;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  logic Key_P_flag = 1'b0;
  logic Key_R_flag = 1'b0;
  logic Short_flag, Double_flag, Long_flag, Repeat_flag, Key_held;

  int checks = 0;
  int failures = 0;

  int n_short, n_dbl, n_long, n_rpt;
  int c_short, c_dbl, c_long, c_rpt, c_rpt2;
  int multi = 0;
  logic held_log [0:63];

  key_event_decoder #(
    .LONG_CNT (20),
    .DBL_CNT  (8),
    .RPT_CNT  (5),
    .CNT_W    (5)
  ) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .Key_P_flag  (Key_P_flag),
    .Key_R_flag  (Key_R_flag),
    .Short_flag  (Short_flag),
    .Double_flag (Double_flag),
    .Long_flag   (Long_flag),
    .Repeat_flag (Repeat_flag),
    .Key_held    (Key_held)
  );

  always #5 Clk = ~Clk;

  task automatic step(input logic p, input logic r, input logic rst_b);
    Key_P_flag = p;
    Key_R_flag = r;
    Reset_n    = rst_b;
    @(posedge Clk);
    #1;
    Key_P_flag = 1'b0;
    Key_R_flag = 1'b0;
    Reset_n    = 1'b1;
  endtask

  // Drive a window of len cycles with up to three P and two R pulses and
  // one reset cycle (-1 = unused); log event counts and first cycles.
  task automatic run(input int len, input int p_a, input int p_b, input int p_c,
                     input int r_a, input int r_b, input int rst_at);
    n_short = 0; n_dbl = 0; n_long = 0; n_rpt = 0;
    c_short = -1; c_dbl = -1; c_long = -1; c_rpt = -1; c_rpt2 = -1;
    for (int i = 0; i < len; i++) begin
      step((i == p_a) || (i == p_b) || (i == p_c), (i == r_a) || (i == r_b), !(i == rst_at));
      if (Short_flag === 1'b1) begin if (n_short == 0) c_short = i; n_short++; end
      if (Double_flag === 1'b1) begin if (n_dbl == 0) c_dbl = i; n_dbl++; end
      if (Long_flag === 1'b1) begin if (n_long == 0) c_long = i; n_long++; end
      if (Repeat_flag === 1'b1) begin
        if (n_rpt == 0) c_rpt = i;
        else if (n_rpt == 1) c_rpt2 = i;
        n_rpt++;
      end
      if ((int'(Short_flag) + int'(Double_flag) + int'(Long_flag) + int'(Repeat_flag)) > 1) multi++;
      if (i < 64) held_log[i] = Key_held;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0);
      checks++;
      if ({Short_flag, Double_flag, Long_flag, Repeat_flag, Key_held} !== 5'b0) begin
        failures++;
        $display("FAIL reset_outputs cycle=%0d got=%b exp=00000", i,
                 {Short_flag, Double_flag, Long_flag, Repeat_flag, Key_held});
      end
    end
    run(10, -1, -1, -1, 4, -1, -1);
    checks++;
    if ((n_short + n_dbl + n_long + n_rpt) !== 0) begin
      failures++; $display("FAIL reset_idle_events got=%0d exp=0", n_short + n_dbl + n_long + n_rpt);
    end
    checks++;
    if (held_log[9] !== 1'b0) begin
      failures++; $display("FAIL reset_idle_held got=%b exp=0", held_log[9]);
    end
  endtask

  task automatic test_short();
    run(24, 0, -1, -1, 5, -1, -1);
    checks++; if (held_log[0] !== 1'b1) begin failures++; $display("FAIL short_held_pressed got=%b exp=1", held_log[0]); end
    checks++; if (held_log[5] !== 1'b0) begin failures++; $display("FAIL short_held_released got=%b exp=0", held_log[5]); end
    checks++; if (n_short !== 1) begin failures++; $display("FAIL short_count got=%0d exp=1", n_short); end
    checks++; if (c_short !== 13) begin failures++; $display("FAIL short_cycle got=%0d exp=13", c_short); end
    checks++; if ((n_dbl + n_long + n_rpt) !== 0) begin failures++; $display("FAIL short_other_events got=%0d exp=0", n_dbl + n_long + n_rpt); end
  endtask

  task automatic test_double();
    run(26, 0, 7, -1, 4, 11, -1);
    checks++; if (held_log[8] !== 1'b1) begin failures++; $display("FAIL double_held_second got=%b exp=1", held_log[8]); end
    checks++; if (n_dbl !== 1) begin failures++; $display("FAIL double_count got=%0d exp=1", n_dbl); end
    checks++; if (c_dbl !== 11) begin failures++; $display("FAIL double_cycle got=%0d exp=11", c_dbl); end
    checks++; if (n_short !== 0) begin failures++; $display("FAIL double_no_short got=%0d exp=0", n_short); end
  endtask

  task automatic test_long_repeat();
    run(45, 0, -1, -1, 32, -1, -1);
    checks++; if (n_long !== 1) begin failures++; $display("FAIL long_count got=%0d exp=1", n_long); end
    checks++; if (c_long !== 20) begin failures++; $display("FAIL long_cycle got=%0d exp=20", c_long); end
    checks++; if (n_rpt !== 2) begin failures++; $display("FAIL repeat_count got=%0d exp=2", n_rpt); end
    checks++; if (c_rpt !== 25) begin failures++; $display("FAIL repeat_first got=%0d exp=25", c_rpt); end
    checks++; if (c_rpt2 !== 30) begin failures++; $display("FAIL repeat_second got=%0d exp=30", c_rpt2); end
    checks++; if (held_log[31] !== 1'b1) begin failures++; $display("FAIL long_held_before_rel got=%b exp=1", held_log[31]); end
    checks++; if (held_log[32] !== 1'b0) begin failures++; $display("FAIL long_held_after_rel got=%b exp=0", held_log[32]); end
    checks++; if ((n_short + n_dbl) !== 0) begin failures++; $display("FAIL long_other_events got=%0d exp=0", n_short + n_dbl); end
  endtask

  task automatic test_collisions();
    // Release exactly on long timeout
    run(40, 0, -1, -1, 20, -1, -1);
    checks++; if (n_long !== 0) begin failures++; $display("FAIL coll_long_suppressed got=%0d exp=0", n_long); end
    checks++; if (c_short !== 28) begin failures++; $display("FAIL coll_long_short_cycle got=%0d exp=28", c_short); end
    // Second press exactly on double-click timeout
    run(25, 0, 12, -1, 4, 15, -1);
    checks++; if (n_short !== 0) begin failures++; $display("FAIL coll_dbl_short_suppressed got=%0d exp=0", n_short); end
    checks++; if (c_dbl !== 15) begin failures++; $display("FAIL coll_dbl_double_cycle got=%0d exp=15", c_dbl); end
    // Release exactly on repeat timeout
    run(35, 0, -1, -1, 25, -1, -1);
    checks++; if (n_rpt !== 0) begin failures++; $display("FAIL coll_rpt_suppressed got=%0d exp=0", n_rpt); end
    checks++; if (held_log[25] !== 1'b0) begin failures++; $display("FAIL coll_rpt_held got=%b exp=0", held_log[25]); end
    // P and R together while PRESSED: only R acts
    run(30, 0, 3, -1, 3, -1, -1);
    checks++; if (c_short !== 11) begin failures++; $display("FAIL both_flags_short_cycle got=%0d exp=11", c_short); end
    checks++; if (n_dbl !== 0) begin failures++; $display("FAIL both_flags_no_double got=%0d exp=0", n_dbl); end
  endtask

  task automatic test_second_timeout();
    run(40, 0, 4, 26, 2, 30, -1);
    checks++; if (c_dbl !== 24) begin failures++; $display("FAIL second_to_double_cycle got=%0d exp=24", c_dbl); end
    checks++; if (n_dbl !== 1) begin failures++; $display("FAIL second_to_double_count got=%0d exp=1", n_dbl); end
    checks++; if (held_log[28] !== 1'b1) begin failures++; $display("FAIL wait_rel_held got=%b exp=1", held_log[28]); end
    checks++; if (held_log[30] !== 1'b0) begin failures++; $display("FAIL wait_rel_release got=%b exp=0", held_log[30]); end
    checks++; if ((n_short + n_long + n_rpt) !== 0) begin failures++; $display("FAIL wait_rel_other got=%0d exp=0", n_short + n_long + n_rpt); end
  endtask

  task automatic test_mid_reset();
    run(50, 0, -1, -1, -1, -1, 23);
    checks++; if (n_long !== 1) begin failures++; $display("FAIL midrst_held_long got=%0d exp=1", n_long); end
    checks++; if (n_rpt !== 0) begin failures++; $display("FAIL midrst_held_repeat got=%0d exp=0", n_rpt); end
    checks++; if (held_log[23] !== 1'b0) begin failures++; $display("FAIL midrst_held_level got=%b exp=0", held_log[23]); end
    run(30, 0, -1, -1, 3, -1, 5);
    checks++; if ((n_short + n_dbl) !== 0) begin failures++; $display("FAIL midrst_wait_dbl got=%0d exp=0", n_short + n_dbl); end
    run(24, 0, -1, -1, 5, -1, -1);
    checks++; if (c_short !== 13) begin failures++; $display("FAIL midrst_fresh_short got=%0d exp=13", c_short); end
  endtask

  task automatic test_no_overlap();
    checks++;
    if (multi !== 0) begin failures++; $display("FAIL overlap_cycles got=%0d exp=0", multi); end
  endtask

  initial begin
    test_reset();
    test_short();
    test_double();
    test_long_repeat();
    test_collisions();
    test_second_timeout();
    test_mid_reset();
    test_no_overlap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
